// File: rtl/cherry_pkg.sv
// cherry_pkg: shared types and constants
// for the Control Unit decode path.
package cherry_pkg;

  localparam int LOOP_DESC_W = 24;

  localparam logic [2:0] INSTR_TYPE_LOAD_STORE = 3'd0;
  localparam logic [2:0] INSTR_TYPE_RAM        = 3'd1;
  localparam logic [2:0] INSTR_TYPE_ARITHMETIC = 3'd2;
  localparam logic [2:0] INSTR_TYPE_LOOP       = 3'd3;
  localparam logic [2:0] INSTR_TYPE_PROG_END   = 3'd4;

  typedef struct packed {
    logic        is_new_loop;
    logic        is_independent;
    logic [2:0]  name;
    logic [17:0] iteration_count;
    logic [5:0]  jump_amount;
  } decoded_loop_instruction;

endpackage

// File: rtl/loop_mux.sv
// loop_mux: loop instruction decoder,
// descriptor mux plus registered copy.
module loop_mux
  import cherry_pkg::*;
#(
  parameter int LOG_LOOP_CNT = 3,
  parameter int ITER_W       = 18,
  parameter int JUMP_W       = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LOG_LOOP_CNT-1:0] addr,
  input  logic [(1<<LOG_LOOP_CNT)*LOOP_DESC_W-1:0] in,
  input  logic                    independent,
  input  logic                    new_loop,
  output decoded_loop_instruction loop_instr,
  output decoded_loop_instruction loop_instr_q,
  output logic                    zero_iter
);

  logic [LOOP_DESC_W-1:0]  w_desc;
  decoded_loop_instruction w_instr;
  decoded_loop_instruction r_instr_q;

  // Pick one descriptor with a flat 8-way case
  always_comb begin
    w_desc = '0;
    unique case (addr)
      3'd0: w_desc = in[0*LOOP_DESC_W +: LOOP_DESC_W];
      3'd1: w_desc = in[1*LOOP_DESC_W +: LOOP_DESC_W];
      3'd2: w_desc = in[2*LOOP_DESC_W +: LOOP_DESC_W];
      3'd3: w_desc = in[3*LOOP_DESC_W +: LOOP_DESC_W];
      3'd4: w_desc = in[4*LOOP_DESC_W +: LOOP_DESC_W];
      3'd5: w_desc = in[5*LOOP_DESC_W +: LOOP_DESC_W];
      3'd6: w_desc = in[6*LOOP_DESC_W +: LOOP_DESC_W];
      3'd7: w_desc = in[7*LOOP_DESC_W +: LOOP_DESC_W];
      default: w_desc = '0;
    endcase
  end

  // Merge descriptor fields with the raw flag bits
  always_comb begin
    w_instr                 = '0;
    w_instr.is_new_loop     = new_loop;
    w_instr.is_independent  = independent;
    w_instr.name            = addr;
    w_instr.iteration_count = w_desc[JUMP_W +: ITER_W];
    w_instr.jump_amount     = w_desc[0 +: JUMP_W];
  end

  // Hold the decode for later FSM states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_instr_q <= '0;
    else        r_instr_q <= w_instr;
  end

  assign loop_instr   = w_instr;
  assign loop_instr_q = r_instr_q;
  assign zero_iter    = (w_desc[JUMP_W +: ITER_W] == '0);

endmodule

// File: tb/tb_loop_mux.sv
// tb_loop_mux: directed bench with a
// scoreboard for the registered output.
module tb_loop_mux;
  import cherry_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   addr;
  logic [191:0] din;
  logic         independent;
  logic         new_loop;
  decoded_loop_instruction loop_instr;
  decoded_loop_instruction loop_instr_q;
  logic         zero_iter;

  int n_pass = 0;
  int n_chk  = 0;
  decoded_loop_instruction exp_q[$];
  decoded_loop_instruction last_q;
  decoded_loop_instruction m;

  loop_mux dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .in           (din),
    .independent  (independent),
    .new_loop     (new_loop),
    .loop_instr   (loop_instr),
    .loop_instr_q (loop_instr_q),
    .zero_iter    (zero_iter)
  );

  function automatic decoded_loop_instruction model();
    decoded_loop_instruction r;
    logic [23:0] d;
    d = din[int'(addr)*24 +: 24];
    r.is_new_loop     = new_loop;
    r.is_independent  = independent;
    r.name            = addr;
    r.iteration_count = d[23:6];
    r.jump_amount     = d[5:0];
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [28:0] obs,
                     input logic [28:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic comb_check(input string tag);
    #1;
    m = model();
    chk({tag, "_comb"}, loop_instr, m);
    chk({tag, "_zero"}, 29'(zero_iter),
        29'(m.iteration_count == 18'd0));
  endtask

  task automatic edge_step(input string tag);
    decoded_loop_instruction e;
    exp_q.push_back(model());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_q"}, loop_instr_q, e);
    last_q = e;
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    addr        = 3'd0;
    independent = 1'b0;
    new_loop    = 1'b0;
    din         = '0;
    for (int k = 0; k < 8; k++)
      din[k*24 +: 24] = {18'(k*100+1), 6'(k+2)};
    @(negedge clk);
    #1;
    chk("reset_q", loop_instr_q, 29'd0);
    addr = 3'd1;
    comb_check("reset_comb");
    reset = 1'b1;
    @(negedge clk);

    // descriptor sweep
    for (int k = 0; k < 8; k++) begin
      addr = 3'(k);
      comb_check($sformatf("sel%0d", k));
      chk($sformatf("sel%0d_iter", k),
          29'(loop_instr.iteration_count),
          29'(k*100+1));
      chk($sformatf("sel%0d_jump", k),
          29'(loop_instr.jump_amount), 29'(k+2));
      chk($sformatf("sel%0d_name", k),
          29'(loop_instr.name), 29'(k));
      edge_step($sformatf("sel%0d", k));
    end

    // flag pass-through
    addr = 3'd5;
    for (int f = 0; f < 4; f++) begin
      new_loop    = f[1];
      independent = f[0];
      comb_check($sformatf("flag%0d", f));
      chk($sformatf("flag%0d_nl", f),
          29'(loop_instr.is_new_loop), 29'(f[1]));
      chk($sformatf("flag%0d_ind", f),
          29'(loop_instr.is_independent), 29'(f[0]));
      chk($sformatf("flag%0d_iter", f),
          29'(loop_instr.iteration_count), 29'd501);
      edge_step($sformatf("flag%0d", f));
    end

    // field boundaries
    new_loop    = 1'b1;
    independent = 1'b0;
    din[7*24 +: 24] = 24'hFFFFFF;
    din[0*24 +: 24] = 24'h00003F;
    addr = 3'd7;
    comb_check("bnd7");
    chk("bnd7_iter", 29'(loop_instr.iteration_count),
        29'h3FFFF);
    chk("bnd7_jump", 29'(loop_instr.jump_amount), 29'h3F);
    chk("bnd7_zero", 29'(zero_iter), 29'd0);
    edge_step("bnd7");
    addr = 3'd0;
    comb_check("bnd0");
    chk("bnd0_iter", 29'(loop_instr.iteration_count), 29'd0);
    chk("bnd0_jump", 29'(loop_instr.jump_amount), 29'd63);
    chk("bnd0_zero", 29'(zero_iter), 29'd1);
    edge_step("bnd0");

    // register latency
    addr = 3'd2;
    comb_check("lat2");
    edge_step("lat2");
    addr = 3'd6;
    comb_check("lat6");
    chk("lat6_iter", 29'(loop_instr.iteration_count), 29'd601);
    chk("lat6_hold", loop_instr_q, last_q);
    edge_step("lat6");
    chk("lat6_qiter", 29'(loop_instr_q.iteration_count),
        29'd601);

    // asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("arst_q", loop_instr_q, 29'd0);
    addr = 3'd3;
    comb_check("arst");
    @(posedge clk);
    #1;
    chk("arst_hold", loop_instr_q, 29'd0);
    @(negedge clk);
    reset = 1'b1;
    comb_check("rel");
    edge_step("rel");
    chk("rel_qname", 29'(loop_instr_q.name), 29'd3);

    // simultaneous descriptor and address change
    din[4*24 +: 24] = {18'h2A5A5, 6'h15};
    addr = 3'd4;
    independent = 1'b1;
    comb_check("simul");
    chk("simul_iter", 29'(loop_instr.iteration_count),
        29'h2A5A5);
    chk("simul_jump", 29'(loop_instr.jump_amount), 29'h15);
    edge_step("simul");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
